timer_ctrl_master: RTL and testbench

- Avalon-MM master that drives the 16-bit interval-timer slave: programs the period, starts and stops the timer, services timeouts, and captures snapshots.
- Register map used: 0 status (write clears timeout; bit0 timeout, bit1 running), 1 control (bit3 stop, bit2 start, bit1 continuous, bit0 irq enable), 2/3 period low/high, 4/5 snapshot low/high.
- Sits between a fabric command source and the timer.
- Presents tick pulses, a tick counter and snapshot values to local logic.

---
 rtl/timer_ctrl_master.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_timer_ctrl_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_master.sv
// ---------------------------------------------------------------------------
// timer_ctrl_master
//
// Avalon-MM master for a 16-bit interval-timer slave. It programs the period,
// starts and stops the timer, services timeouts (by interrupt or by polling
// the status register) and captures counter snapshots for local logic.
//
// Slave register map (word addresses):
//   0 status   (write clears timeout; bit0 timeout, bit1 running)
//   1 control  (bit3 stop, bit2 start, bit1 continuous, bit0 irq enable)
//   2/3 period low/high      4/5 snapshot low/high
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cmd_start           pulse: program period/mode and start the timer
//   cmd_stop            pulse: stop the timer and clear any pending timeout
//   cmd_snap            pulse: capture and read back the timer counter
//   cmd_period          32-bit load value (0 is promoted to 1), on cmd_start
//   cmd_continuous      continuous mode, sampled on cmd_start
//   cmd_irq_en          1 = wait for timer_irq, 0 = poll status every POLL_GAP
//   busy                a bus sequence is in progress (state not IDLE/WAIT)
//   running             timer started and not yet stopped or completed
//   tick                one-cycle pulse per serviced timeout
//   tick_count          serviced timeouts, wraps modulo 2^TICK_W
//   snap_value          last captured snapshot
//   snap_valid          one-cycle pulse when snap_value updates
//   avm_*               Avalon-MM master side; one cycle per access, no
//                       waitrequest, read data returns on the next cycle
//   timer_irq           level interrupt from the timer
// ---------------------------------------------------------------------------
module timer_ctrl_master #(
   parameter int TICK_W   = 16,
   parameter int POLL_GAP = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   input  logic              cmd_snap,
   input  logic [31:0]       cmd_period,
   input  logic              cmd_continuous,
   input  logic              cmd_irq_en,
   output logic              busy,
   output logic              running,
   output logic              tick,
   output logic [TICK_W-1:0] tick_count,
   output logic [31:0]       snap_value,
   output logic              snap_valid,
   output logic [2:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic [15:0]       avm_writedata,
   input  logic [15:0]       avm_readdata,
   input  logic              timer_irq
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_PL,
      S_WR_PH,
      S_WR_CTRL,
      S_WAIT,
      S_POLL_RD,
      S_POLL_CHK,
      S_CLR,
      S_SN_WR,
      S_SN_RL,
      S_SN_RH,
      S_SN_DONE,
      S_ST_CTRL,
      S_ST_CLR
   } state_t;

   localparam logic [2:0] ADDR_STATUS = 3'd0;
   localparam logic [2:0] ADDR_CTRL   = 3'd1;
   localparam logic [2:0] ADDR_PER_LO = 3'd2;
   localparam logic [2:0] ADDR_PER_HI = 3'd3;
   localparam logic [2:0] ADDR_SNP_LO = 3'd4;
   localparam logic [2:0] ADDR_SNP_HI = 3'd5;

   localparam logic [15:0] CTRL_STOP  = 16'h0008;
   localparam logic [8:0]  GAP_LIMIT  = 9'(POLL_GAP);

   // Registered state
   state_t              state_q,      state_d;
   logic [31:0]         period_q,     period_d;
   logic                cont_q,       cont_d;
   logic                irq_en_q,     irq_en_d;
   logic                running_q,    running_d;
   logic [TICK_W-1:0]   tick_count_q, tick_count_d;
   logic [15:0]         snap_lo_q,    snap_lo_d;
   logic [31:0]         snap_value_q, snap_value_d;
   logic                snap_valid_q, snap_valid_d;
   logic                from_wait_q,  from_wait_d;
   logic [7:0]          gap_cnt_q,    gap_cnt_d;

   // Bus and pulse outputs decoded from the current state
   logic [2:0]          bus_addr;
   logic                bus_cs;
   logic                bus_write_n;
   logic [15:0]         bus_wdata;
   logic                tick_pulse;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         period_q     <= '0;
         cont_q       <= 1'b0;
         irq_en_q     <= 1'b0;
         running_q    <= 1'b0;
         tick_count_q <= '0;
         snap_lo_q    <= '0;
         snap_value_q <= '0;
         snap_valid_q <= 1'b0;
         from_wait_q  <= 1'b0;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         cont_q       <= cont_d;
         irq_en_q     <= irq_en_d;
         running_q    <= running_d;
         tick_count_q <= tick_count_d;
         snap_lo_q    <= snap_lo_d;
         snap_value_q <= snap_value_d;
         snap_valid_q <= snap_valid_d;
         from_wait_q  <= from_wait_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // skipped an assignment would otherwise infer a latch.
      state_d      = state_q;
      period_d     = period_q;
      cont_d       = cont_q;
      irq_en_d     = irq_en_q;
      running_d    = running_q;
      tick_count_d = tick_count_q;
      snap_lo_d    = snap_lo_q;
      snap_value_d = snap_value_q;
      snap_valid_d = 1'b0;
      from_wait_d  = from_wait_q;
      gap_cnt_d    = gap_cnt_q;

      bus_addr     = '0;
      bus_cs       = 1'b0;
      bus_write_n  = 1'b1;
      bus_wdata    = '0;
      tick_pulse   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_stop) begin
               state_d = S_ST_CTRL;
            end else if (cmd_snap) begin
               state_d     = S_SN_WR;
               from_wait_d = 1'b0;
            end else if (cmd_start) begin
               state_d  = S_WR_PL;
               // A zero period would never time out; load the shortest one.
               period_d = (cmd_period == 32'd0) ? 32'd1 : cmd_period;
               cont_d   = cmd_continuous;
               irq_en_d = cmd_irq_en;
            end
         end

         S_WR_PL: begin
            bus_cs      = 1'b1;
            bus_write_n = 1'b0;
            bus_addr    = ADDR_PER_LO;
            bus_wdata   = period_q[15:0];
            state_d     = S_WR_PH;
         end

         S_WR_PH: begin
            bus_cs      = 1'b1;
            bus_write_n = 1'b0;
            bus_addr    = ADDR_PER_HI;
            bus_wdata   = period_q[31:16];
            state_d     = S_WR_CTRL;
         end

         S_WR_CTRL: begin
            bus_cs      = 1'b1;
            bus_write_n = 1'b0;
            bus_addr    = ADDR_CTRL;
            bus_wdata   = {13'd0, 1'b1, cont_q, irq_en_q};
            running_d   = 1'b1;
            gap_cnt_d   = '0;
            state_d     = S_WAIT;
         end

         S_WAIT: begin
            // Stop and snapshot both outrank a timeout seen this cycle. A
            // timeout deferred by a snapshot is still pending afterwards.
            if (cmd_stop) begin
               state_d = S_ST_CTRL;
            end else if (cmd_snap) begin
               state_d     = S_SN_WR;
               from_wait_d = 1'b1;
            end else if (irq_en_q) begin
               if (timer_irq) begin
                  state_d = S_CLR;
               end
            end else if (({1'b0, gap_cnt_q} + 9'd1) >= GAP_LIMIT) begin
               state_d = S_POLL_RD;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end

         S_POLL_RD: begin
            bus_cs   = 1'b1;
            bus_addr = ADDR_STATUS;
            state_d  = S_POLL_CHK;
         end

         S_POLL_CHK: begin
            if (avm_readdata[0]) begin
               state_d = S_CLR;
            end else begin
               // The check cycle already counts as one idle cycle of the gap.
               state_d   = S_WAIT;
               gap_cnt_d = 8'd1;
            end
         end

         S_CLR: begin
            bus_cs       = 1'b1;
            bus_write_n  = 1'b0;
            bus_addr     = ADDR_STATUS;
            tick_pulse   = 1'b1;
            tick_count_d = tick_count_q + TICK_W'(1);
            if (cont_q) begin
               state_d   = S_WAIT;
               gap_cnt_d = '0;
            end else begin
               state_d   = S_IDLE;
               running_d = 1'b0;
            end
         end

         S_SN_WR: begin
            bus_cs      = 1'b1;
            bus_write_n = 1'b0;
            bus_addr    = ADDR_SNP_LO;
            state_d     = S_SN_RL;
         end

         S_SN_RL: begin
            bus_cs   = 1'b1;
            bus_addr = ADDR_SNP_LO;
            state_d  = S_SN_RH;
         end

         S_SN_RH: begin
            // Read data lags the address by one cycle: this is the low half.
            bus_cs    = 1'b1;
            bus_addr  = ADDR_SNP_HI;
            snap_lo_d = avm_readdata;
            state_d   = S_SN_DONE;
         end

         S_SN_DONE: begin
            snap_value_d = {avm_readdata, snap_lo_q};
            snap_valid_d = 1'b1;
            gap_cnt_d    = '0;
            state_d      = from_wait_q ? S_WAIT : S_IDLE;
         end

         S_ST_CTRL: begin
            bus_cs      = 1'b1;
            bus_write_n = 1'b0;
            bus_addr    = ADDR_CTRL;
            bus_wdata   = CTRL_STOP;
            state_d     = S_ST_CLR;
         end

         S_ST_CLR: begin
            // Discards any pending timeout without reporting a tick.
            bus_cs      = 1'b1;
            bus_write_n = 1'b0;
            bus_addr    = ADDR_STATUS;
            running_d   = 1'b0;
            state_d     = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy           = (state_q != S_IDLE) && (state_q != S_WAIT);
   assign running        = running_q;
   assign tick           = tick_pulse;
   assign tick_count     = tick_count_q;
   assign snap_value     = snap_value_q;
   assign snap_valid     = snap_valid_q;
   assign avm_address    = bus_addr;
   assign avm_chipselect = bus_cs;
   assign avm_write_n    = bus_write_n;
   assign avm_writedata  = bus_wdata;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl_master
//
// Directed bench for timer_ctrl_master. A small slave model returns
// registered read data (status bit0 on a chosen poll, fixed snapshot halves);
// a negedge monitor logs every bus access, tick and snap_valid pulse. Each
// task drives one scenario and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_timer_ctrl_master;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] data;
      int          cyc;
      logic        tick;
   } bus_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_start, cmd_stop, cmd_snap;
   logic [31:0] cmd_period;
   logic        cmd_continuous, cmd_irq_en;
   logic        busy, running, tick;
   logic [15:0] tick_count;
   logic [31:0] snap_value;
   logic        snap_valid;
   logic [2:0]  avm_address;
   logic        avm_chipselect, avm_write_n;
   logic [15:0] avm_writedata;
   logic [15:0] avm_readdata = 16'h0;
   logic        timer_irq;

   int   checks = 0;
   int   errors = 0;
   int   cyc_n = 0;
   bus_t wr_log[$];
   bus_t rd_log[$];
   int   tick_mon = 0;
   int   snapv_mon = 0;
   int   rd0_cnt = 0;
   int   status_hit_at = 0;

   timer_ctrl_master #(.TICK_W(16), .POLL_GAP(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
      .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
      .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
      .snap_value(snap_value), .snap_valid(snap_valid),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Slave model: read data is registered and appears the cycle after the read.
   always @(posedge clk) begin
      if (avm_chipselect && avm_write_n) begin
         case (avm_address)
            3'd0: begin
               rd0_cnt      <= rd0_cnt + 1;
               avm_readdata <= (rd0_cnt + 1 == status_hit_at) ? 16'h0001 : 16'h0000;
            end
            3'd4:    avm_readdata <= 16'h1234;
            3'd5:    avm_readdata <= 16'h0005;
            default: avm_readdata <= 16'h0000;
         endcase
      end
   end

   // Bus monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (avm_chipselect) begin
         if (!avm_write_n) wr_log.push_back('{avm_address, avm_writedata, cyc_n, tick});
         else              rd_log.push_back('{avm_address, 16'h0, cyc_n, tick});
      end
      if (tick)       tick_mon  <= tick_mon + 1;
      if (snap_valid) snapv_mon <= snapv_mon + 1;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", avm_chipselect); end
      checks++; if (avm_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b expected 1", avm_write_n); end
      checks++; if (avm_address !== 3'd0 || avm_writedata !== 16'h0) begin errors++; $display("FAIL reset_addr_data: got %0d/%h expected 0/0000", avm_address, avm_writedata); end
      checks++; if (busy !== 1'b0 || running !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b running=%b tick=%b expected 0 0 0", busy, running, tick); end
      checks++; if (tick_count !== 16'h0 || snap_value !== 32'h0 || snap_valid !== 1'b0) begin errors++; $display("FAIL reset_values: got count=%h snap=%h valid=%b expected 0", tick_count, snap_value, snap_valid); end
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_irq_continuous();
      int w0 = wr_log.size();
      int t0 = tick_mon;
      logic [2:0]  ea [3] = '{3'd2, 3'd3, 3'd1};
      logic [15:0] ed [3] = '{16'h86A0, 16'h0001, 16'h0007};
      cmd_period = 32'h0001_86A0; cmd_continuous = 1'b1; cmd_irq_en = 1'b1;
      cmd_start = 1'b1; step(1); cmd_start = 1'b0;
      step(4);
      checks++; if (running !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL start_running: got running=%b busy=%b expected 1 0", running, busy); end
      checks++; if (wr_log.size() - w0 !== 3) begin errors++; $display("FAIL start_wr_count: got %0d expected 3", wr_log.size() - w0); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_log[w0+i].addr !== ea[i] || wr_log[w0+i].data !== ed[i] || wr_log[w0+i].cyc !== wr_log[w0].cyc + i)
            begin errors++; $display("FAIL start_wr%0d: got (%0d,%h)@%0d expected (%0d,%h)@%0d", i, wr_log[w0+i].addr, wr_log[w0+i].data, wr_log[w0+i].cyc, ea[i], ed[i], wr_log[w0].cyc + i); end
         end
      end
      for (int k = 0; k < 3; k++) begin
         timer_irq = 1'b1; step(1); timer_irq = 1'b0;
         step(3);
      end
      checks++; if (tick_count !== 16'd3) begin errors++; $display("FAIL irq_tick_count: got %0d expected 3", tick_count); end
      checks++; if (tick_mon - t0 !== 3) begin errors++; $display("FAIL irq_tick_pulses: got %0d expected 3", tick_mon - t0); end
      checks++; if (wr_log.size() - w0 !== 6) begin errors++; $display("FAIL irq_clr_count: got %0d expected 6", wr_log.size() - w0); end
      else begin
         for (int i = 3; i < 6; i++) begin
            checks++;
            if (wr_log[w0+i].addr !== 3'd0 || wr_log[w0+i].data !== 16'h0 || wr_log[w0+i].tick !== 1'b1)
            begin errors++; $display("FAIL irq_clr%0d: got (%0d,%h) tick=%b expected (0,0000) tick=1", i-3, wr_log[w0+i].addr, wr_log[w0+i].data, wr_log[w0+i].tick); end
         end
      end
   endtask

   task automatic test_snapshot();
      int w0 = wr_log.size();
      int r0 = rd_log.size();
      int s0 = snapv_mon;
      bit seen = 1'b0;
      cmd_snap = 1'b1; step(1); cmd_snap = 1'b0;
      step(4);
      checks++; if (snap_value !== 32'h0005_1234) begin errors++; $display("FAIL snap_value: got %h expected 00051234", snap_value); end
      checks++; if (snap_valid !== 1'b1) begin errors++; $display("FAIL snap_valid: got %b expected 1", snap_valid); end
      checks++; if (busy !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL snap_return: got busy=%b running=%b expected 0 1", busy, running); end
      checks++; if (wr_log.size() - w0 !== 1 || rd_log.size() - r0 !== 2) begin errors++; $display("FAIL snap_bus_count: got %0d wr %0d rd expected 1 2", wr_log.size() - w0, rd_log.size() - r0); end
      else begin
         checks++;
         if (wr_log[w0].addr !== 3'd4 || wr_log[w0].data !== 16'h0 || rd_log[r0].addr !== 3'd4 || rd_log[r0+1].addr !== 3'd5 ||
             rd_log[r0].cyc !== wr_log[w0].cyc + 1 || rd_log[r0+1].cyc !== wr_log[w0].cyc + 2)
         begin errors++; $display("FAIL snap_bus_seq: got wr %0d@%0d rd %0d@%0d %0d@%0d expected wr 4 then rd 4, 5 on following cycles", wr_log[w0].addr, wr_log[w0].cyc, rd_log[r0].addr, rd_log[r0].cyc, rd_log[r0+1].addr, rd_log[r0+1].cyc); end
      end
      step(1);
      // Snapshot and timeout in the same cycle: snapshot first, tick after.
      cmd_snap = 1'b1; timer_irq = 1'b1; step(1); cmd_snap = 1'b0;
      checks++; if (busy !== 1'b1 || tick !== 1'b0) begin errors++; $display("FAIL snap_beats_irq: got busy=%b tick=%b expected 1 0", busy, tick); end
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1);
         if (tick === 1'b1) begin seen = 1'b1; timer_irq = 1'b0; end
      end
      timer_irq = 1'b0;
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL snap_deferred_tick: got no tick within 20 cycles expected one"); end
      step(2);
      checks++; if (tick_count !== 16'd4) begin errors++; $display("FAIL snap_tick_count: got %0d expected 4", tick_count); end
      checks++; if (snapv_mon - s0 !== 2) begin errors++; $display("FAIL snap_valid_pulses: got %0d expected 2", snapv_mon - s0); end
   endtask

   task automatic test_stop_irq();
      int w0 = wr_log.size();
      int t0 = tick_mon;
      cmd_stop = 1'b1; timer_irq = 1'b1; step(1); cmd_stop = 1'b0; timer_irq = 1'b0;
      step(3);
      checks++; if (wr_log.size() - w0 !== 2) begin errors++; $display("FAIL stop_wr_count: got %0d expected 2", wr_log.size() - w0); end
      else begin
         checks++;
         if (wr_log[w0].addr !== 3'd1 || wr_log[w0].data !== 16'h0008 || wr_log[w0+1].addr !== 3'd0 || wr_log[w0+1].data !== 16'h0 || wr_log[w0+1].cyc !== wr_log[w0].cyc + 1)
         begin errors++; $display("FAIL stop_wr_seq: got (%0d,%h) (%0d,%h) expected (1,0008) (0,0000)", wr_log[w0].addr, wr_log[w0].data, wr_log[w0+1].addr, wr_log[w0+1].data); end
      end
      checks++; if (tick_mon - t0 !== 0 || tick_count !== 16'd4) begin errors++; $display("FAIL stop_no_tick: got pulses=%0d count=%0d expected 0 4", tick_mon - t0, tick_count); end
      checks++; if (running !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_idle: got running=%b busy=%b expected 0 0", running, busy); end
   endtask

   task automatic test_poll_oneshot();
      int w0 = wr_log.size();
      int r0 = rd_log.size();
      int t0 = tick_mon;
      status_hit_at = rd0_cnt + 3;
      cmd_period = 32'h0000_0010; cmd_continuous = 1'b0; cmd_irq_en = 1'b0;
      cmd_start = 1'b1; step(1); cmd_start = 1'b0;
      for (int i = 0; i < 80 && tick_mon == t0; i++) step(1);
      step(2);
      checks++; if (rd_log.size() - r0 !== 3) begin errors++; $display("FAIL poll_rd_count: got %0d expected 3", rd_log.size() - r0); end
      else begin
         checks++; if (rd_log[r0].addr !== 3'd0 || rd_log[r0+1].addr !== 3'd0 || rd_log[r0+2].addr !== 3'd0) begin errors++; $display("FAIL poll_rd_addr: got %0d %0d %0d expected 0 0 0", rd_log[r0].addr, rd_log[r0+1].addr, rd_log[r0+2].addr); end
         checks++; if (rd_log[r0+1].cyc - rd_log[r0].cyc !== 5 || rd_log[r0+2].cyc - rd_log[r0+1].cyc !== 5) begin errors++; $display("FAIL poll_spacing: got %0d %0d expected 5 5", rd_log[r0+1].cyc - rd_log[r0].cyc, rd_log[r0+2].cyc - rd_log[r0+1].cyc); end
         checks++;
         if (wr_log.size() - w0 !== 4) begin errors++; $display("FAIL poll_wr_count: got %0d expected 4", wr_log.size() - w0); end
         else if (wr_log[w0+3].addr !== 3'd0 || wr_log[w0+3].tick !== 1'b1 || wr_log[w0+3].cyc !== rd_log[r0+2].cyc + 2 || wr_log[w0+2].data !== 16'h0004)
         begin errors++; $display("FAIL poll_clr: got addr=%0d tick=%b @%0d ctrl=%h expected 0 1 @%0d ctrl=0004", wr_log[w0+3].addr, wr_log[w0+3].tick, wr_log[w0+3].cyc, wr_log[w0+2].data, rd_log[r0+2].cyc + 2); end
      end
      checks++; if (running !== 1'b0 || busy !== 1'b0 || tick_count !== 16'd5) begin errors++; $display("FAIL poll_done: got running=%b busy=%b count=%0d expected 0 0 5", running, busy, tick_count); end
   endtask

   task automatic test_period_zero_busy();
      int w0 = wr_log.size();
      int r0 = rd_log.size();
      cmd_period = 32'h0; cmd_continuous = 1'b0; cmd_irq_en = 1'b1;
      cmd_start = 1'b1; step(1); cmd_start = 1'b0;
      cmd_start = 1'b1; step(1); cmd_start = 1'b0;
      step(3);
      checks++; if (wr_log.size() - w0 !== 3) begin errors++; $display("FAIL p0_wr_count: got %0d expected 3", wr_log.size() - w0); end
      else begin
         checks++;
         if (wr_log[w0].addr !== 3'd2 || wr_log[w0].data !== 16'h0001 || wr_log[w0+1].addr !== 3'd3 || wr_log[w0+1].data !== 16'h0000 || wr_log[w0+2].data !== 16'h0005)
         begin errors++; $display("FAIL p0_wr_seq: got (%0d,%h) (%0d,%h) ctrl=%h expected (2,0001) (3,0000) ctrl=0005", wr_log[w0].addr, wr_log[w0].data, wr_log[w0+1].addr, wr_log[w0+1].data, wr_log[w0+2].data); end
      end
      cmd_period = 32'h0000_5555;
      cmd_start = 1'b1; step(1); cmd_start = 1'b0;
      step(4);
      checks++; if (wr_log.size() - w0 !== 3 || rd_log.size() - r0 !== 0) begin errors++; $display("FAIL wait_start_ignored: got %0d wr %0d rd expected 3 0", wr_log.size() - w0, rd_log.size() - r0); end
      checks++; if (busy !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL wait_state: got busy=%b running=%b expected 0 1", busy, running); end
      timer_irq = 1'b1; step(1); timer_irq = 1'b0;
      step(2);
      checks++; if (running !== 1'b0 || tick_count !== 16'd6) begin errors++; $display("FAIL oneshot_irq_done: got running=%b count=%0d expected 0 6", running, tick_count); end
   endtask

   task automatic test_reset_mid();
      int w1;
      logic [2:0]  ea [3] = '{3'd2, 3'd3, 3'd1};
      logic [15:0] ed [3] = '{16'h1234, 16'hABCD, 16'h0007};
      cmd_period = 32'hABCD_1234; cmd_continuous = 1'b1; cmd_irq_en = 1'b1;
      cmd_start = 1'b1; step(1); cmd_start = 1'b0;
      step(1);
      checks++; if (avm_address !== 3'd3 || avm_writedata !== 16'hABCD) begin errors++; $display("FAIL rst_in_wr_ph: got (%0d,%h) expected (3,abcd)", avm_address, avm_writedata); end
      reset = 1'b1;
      step(1);
      checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_bus: got cs=%b wn=%b busy=%b expected 0 1 0", avm_chipselect, avm_write_n, busy); end
      checks++; if (tick_count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL rst_mid_regs: got count=%0d running=%b expected 0 0", tick_count, running); end
      reset = 1'b0;
      step(1);
      w1 = wr_log.size();
      cmd_start = 1'b1; step(1); cmd_start = 1'b0;
      step(4);
      checks++; if (wr_log.size() - w1 !== 3) begin errors++; $display("FAIL replay_wr_count: got %0d expected 3", wr_log.size() - w1); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_log[w1+i].addr !== ea[i] || wr_log[w1+i].data !== ed[i])
            begin errors++; $display("FAIL replay_wr%0d: got (%0d,%h) expected (%0d,%h)", i, wr_log[w1+i].addr, wr_log[w1+i].data, ea[i], ed[i]); end
         end
      end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL replay_running: got %b expected 1", running); end
   endtask

   initial begin
      reset = 1'b1;
      cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0;
      cmd_period = 32'h0; cmd_continuous = 1'b0; cmd_irq_en = 1'b0;
      timer_irq = 1'b0;
      test_reset();
      test_irq_continuous();
      test_snapshot();
      test_stop_irq();
      test_poll_oneshot();
      test_period_zero_busy();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
